// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - instruction-cache request/response and instruction-head bundle for fetch_queue
interface fetch_queue_if;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memGnt;
    logic        memValid;
    logic [31:0] memData;
    logic        instrValid;
    logic [31:0] instruction;
    logic [31:0] instrPC;
    logic        instrReady;

    modport master (
        output memReq, memAddr, instrValid, instruction, instrPC,
        input  memGnt, memValid, memData, instrReady
    );

    modport slave (
        input  memReq, memAddr, instrValid, instruction, instrPC,
        output memGnt, memValid, memData, instrReady
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - single-outstanding instruction prefetch queue; FETCHQ_PERF_EN adds the fetchCount pop counter
// Flush discards queued entries and turns an in-flight fetch into a drained one.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          clock,
    input  logic          resetN,
    input  logic          flush,
    input  logic [31:0]   flushTarget,
    fetch_queue_if.master bus
`ifdef FETCHQ_PERF_EN
    ,
    output logic [15:0]   fetchCount
`endif
);

    localparam int unsigned   PW   = $clog2(DEPTH);
    localparam int unsigned   CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e        state_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   wait_pc_q;
    logic          mem_req_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];

    logic grant;
    logic push;
    logic pop;
    logic next_fetch;

    // memReq is only ever registered high while in FETCH, so a grant implies FETCH.
    assign grant = mem_req_q & bus.memGnt;
    assign push  = (state_q == S_WAIT) & bus.memValid & ~flush;
    assign pop   = (count_q != '0) & bus.instrReady & ~flush;

    // FETCH is left only by a grant; WAIT and DRAIN return to FETCH on any response.
    assign next_fetch = (state_q == S_FETCH) ? ~grant : bus.memValid;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC & ~32'h3;
            wait_pc_q  <= '0;
            mem_req_q  <= 1'b0;
        end else begin
            mem_req_q <= next_fetch & (count_d < FULL);
            case (state_q)
                S_FETCH: begin
                    if (grant) begin
                        state_q    <= flush ? S_DRAIN : S_WAIT;
                        wait_pc_q  <= fetch_pc_q;
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                    end
                end
                S_WAIT: begin
                    if (bus.memValid) begin
                        state_q <= S_FETCH;
                    end else if (flush) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (bus.memValid) begin
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
            if (flush) begin
                fetch_pc_q <= {flushTarget[31:2], 2'b00};
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr_q] <= bus.memData;
                pc_q[wr_ptr_q]   <= wait_pc_q;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    assign bus.memReq      = mem_req_q;
    assign bus.memAddr     = fetch_pc_q;
    assign bus.instrValid  = (count_q != '0);
    assign bus.instruction = data_q[rd_ptr_q];
    assign bus.instrPC     = pc_q[rd_ptr_q];

`ifdef FETCHQ_PERF_EN
    logic [15:0] fetch_count_q;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            fetch_count_q <= '0;
        end else if (pop && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_q <= fetch_count_q + 16'd1;
        end
    end

    assign fetchCount = fetch_count_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed bench for fetch_queue with a queue-level reference model
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } rsp_t;

    logic        clock;
    logic        resetN;
    logic        flush;
    logic [31:0] flushTarget;
`ifdef FETCHQ_PERF_EN
    logic [15:0] fetchCount;
`endif

    fetch_queue_if bus();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock      (clock),
        .resetN     (resetN),
        .flush      (flush),
        .flushTarget(flushTarget),
        .bus        (bus)
`ifdef FETCHQ_PERF_EN
        ,
        .fetchCount (fetchCount)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int resp_delay  = 1;

    ent_t        mq[$];
    rsp_t        rsp_q[$];
    logic [31:0] m_pc   = RESET_PC;
    logic [31:0] m_oaddr;
    int          m_out  = 0;       // 0 none, 1 response wanted, 2 response to discard
    logic        m_req  = 1'b0;
    logic [15:0] m_pops = '0;

    logic        rec_on      = 1'b0;
    logic        log_on      = 1'b0;
    int          first_grant = -1;
    int          first_valid = -1;
    int          grant_cnt   = 0;
    logic [31:0] pop_log[$];

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h3C3C_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        bus.memValid = 1'b0;
        bus.memData  = '0;
        if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
            bus.memValid = 1'b1;
            bus.memData  = data_of(rsp_q[0].addr);
            void'(rsp_q.pop_front());
        end
    endtask

    // Reference model and per-cycle comparison against it.
    always @(negedge clock) begin
        ent_t e;
        logic granted;
        if (!resetN) begin
            mq.delete();
            m_pc   = RESET_PC;
            m_out  = 0;
            m_req  = 1'b0;
            m_pops = '0;
        end
        chk("memReq", bus.memReq, m_req);
        if (m_req) chk("memAddr", bus.memAddr, m_pc);
        chk("instrValid", bus.instrValid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("instrPC", bus.instrPC, mq[0].pc);
            chk("instruction", bus.instruction, mq[0].data);
        end
`ifdef FETCHQ_PERF_EN
        chk("fetchCount", fetchCount, m_pops);
`endif
        if (bus.memReq && bus.memGnt) begin
            rsp_t r;
            r.due  = cyc + resp_delay;
            r.addr = bus.memAddr;
            rsp_q.push_back(r);
            grant_cnt++;
            if (rec_on && first_grant < 0) first_grant = cyc;
        end
        if (rec_on && first_grant >= 0 && first_valid < 0 && bus.instrValid) first_valid = cyc;

        if (resetN) begin
            granted = m_req && bus.memGnt;
            if (mq.size() != 0 && bus.instrReady && !flush) begin
                if (log_on) pop_log.push_back(mq[0].pc);
                void'(mq.pop_front());
                if (m_pops != 16'hFFFF) m_pops++;
            end
            if (m_out == 0) begin
                if (granted) begin
                    m_out   = flush ? 2 : 1;
                    m_oaddr = m_pc;
                    m_pc    = m_pc + 32'd4;
                end
            end else if (bus.memValid) begin
                if (m_out == 1 && !flush) begin
                    e.pc   = m_oaddr;
                    e.data = bus.memData;
                    mq.push_back(e);
                end
                m_out = 0;
            end else if (flush) begin
                m_out = 2;
            end
            if (flush) begin
                mq.delete();
                m_pc = flushTarget & ~32'h3;
            end
            m_req = (m_out == 0) && (mq.size() < DEPTH);
        end
    end

    initial begin
        int rel_cyc;
        logic found;
        resetN         = 1'b0;
        flush          = 1'b0;
        flushTarget    = '0;
        bus.memGnt     = 1'b0;
        bus.memValid   = 1'b0;
        bus.memData    = '0;
        bus.instrReady = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_memReq", bus.memReq, 1'b0);
        chk("rst_instrValid", bus.instrValid, 1'b0);
        chk("rst_instruction", bus.instruction, 32'h0);
        chk("rst_instrPC", bus.instrPC, 32'h0);

        // Streaming with grant tied high and one-cycle response
        resetN         = 1'b1;
        rel_cyc        = cyc;
        rec_on         = 1'b1;
        log_on         = 1'b1;
        bus.memGnt     = 1'b1;
        bus.instrReady = 1'b1;
        repeat (16) step();
        rec_on = 1'b0;
        log_on = 1'b0;
        chk("first_grant_cycle", first_grant, rel_cyc + 1);
        chk("grant_to_valid", first_valid - first_grant, 2);
        chk("pop_log_len_ok", pop_log.size() >= 4, 1'b1);
        if (pop_log.size() >= 4) begin
            chk("pop0_pc", pop_log[0], 32'h0);
            chk("pop1_pc", pop_log[1], 32'h4);
            chk("pop2_pc", pop_log[2], 32'h8);
            chk("pop3_pc", pop_log[3], 32'hC);
        end
        bus.memGnt = 1'b0;
        repeat (6) step();

        // Fill to DEPTH with no consumer, then one pop re-enables requests
        flushTarget    = 32'h1000;
        flush          = 1'b1;
        bus.instrReady = 1'b0;
        step();
        flush      = 1'b0;
        grant_cnt  = 0;
        bus.memGnt = 1'b1;
        repeat (14) step();
        chk("full_grants", grant_cnt, 4);
        chk("full_memReq", bus.memReq, 1'b0);
        chk("full_instrPC", bus.instrPC, 32'h1000);
        bus.instrReady = 1'b1;
        step();
        bus.instrReady = 1'b0;
        chk("repop_memReq", bus.memReq, 1'b1);
        chk("repop_memAddr", bus.memAddr, 32'h1010);
        bus.memGnt     = 1'b0;
        bus.instrReady = 1'b1;
        repeat (8) step();

        // Flush while a response is pending: response drained, refetch from target
        flushTarget = 32'h8;
        flush       = 1'b1;
        step();
        flush      = 1'b0;
        bus.memGnt = 1'b1;
        resp_delay = 2;
        step();
        bus.memGnt  = 1'b0;
        flushTarget = 32'h100;
        flush       = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("drain_memReq", bus.memReq, 1'b1);
        chk("drain_memAddr", bus.memAddr, 32'h100);
        chk("drain_instrValid", bus.instrValid, 1'b0);
        bus.memGnt     = 1'b1;
        resp_delay     = 1;
        bus.instrReady = 1'b0;
        for (int i = 0; i < 10 && !bus.instrValid; i++) step();
        chk("post_flush_valid", bus.instrValid, 1'b1);
        chk("post_flush_pc", bus.instrPC, 32'h100);
        bus.memGnt     = 1'b0;
        bus.instrReady = 1'b1;
        repeat (8) step();

        // Flush coinciding with a response and a pop at count 2
        flushTarget    = 32'h200;
        flush          = 1'b1;
        bus.instrReady = 1'b0;
        step();
        flush      = 1'b0;
        bus.memGnt = 1'b1;
        found      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mq.size() == 2 && m_out == 1 && bus.memValid) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("setup_count2", found, 1'b1);
        chk("setup_count2_valid", bus.instrValid, 1'b1);
        flushTarget    = 32'h300;
        flush          = 1'b1;
        bus.instrReady = 1'b1;
        bus.memGnt     = 1'b0;
        step();
        flush          = 1'b0;
        bus.instrReady = 1'b0;
        chk("flush_pop_instrValid", bus.instrValid, 1'b0);
        chk("flush_pop_memReq", bus.memReq, 1'b1);
        chk("flush_pop_memAddr", bus.memAddr, 32'h300);

        // Fetch address wraps past the top of the address space
        flushTarget = 32'hFFFF_FFFC;
        flush       = 1'b1;
        step();
        flush      = 1'b0;
        bus.memGnt = 1'b1;
        step();
        bus.memGnt = 1'b0;
        step();
        chk("wrap_memReq", bus.memReq, 1'b1);
        chk("wrap_memAddr", bus.memAddr, 32'h0);
        chk("wrap_instrPC", bus.instrPC, 32'hFFFF_FFFC);
        chk("wrap_instruction", bus.instruction, data_of(32'hFFFF_FFFC));

        // Asynchronous reset while waiting with three entries queued
        bus.instrReady = 1'b1;
        repeat (4) step();
        flushTarget = 32'h400;
        flush       = 1'b1;
        step();
        flush          = 1'b0;
        bus.instrReady = 1'b0;
        bus.memGnt     = 1'b1;
        found          = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mq.size() == 3 && m_out == 0) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("setup_count3", found, 1'b1);
        resp_delay = 3;
        step();
        bus.memGnt = 1'b0;
        resetN     = 1'b0;
        #1;
        chk("async_memReq", bus.memReq, 1'b0);
        chk("async_instrValid", bus.instrValid, 1'b0);
        chk("async_instruction", bus.instruction, 32'h0);
        chk("async_instrPC", bus.instrPC, 32'h0);
`ifdef FETCHQ_PERF_EN
        chk("async_fetchCount", fetchCount, 16'h0);
`endif
        step();
        resetN = 1'b1;
        step();
        chk("late_rsp_memValid_seen", bus.memValid, 1'b1);
        step();
        chk("late_rsp_ignored", bus.instrValid, 1'b0);
        bus.memGnt = 1'b1;
        resp_delay = 1;
        for (int i = 0; i < 10 && !bus.instrValid; i++) step();
        chk("post_reset_valid", bus.instrValid, 1'b1);
        chk("post_reset_pc", bus.instrPC, RESET_PC);
        bus.memGnt = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
